// File: rtl/persiana_pkg.sv
// Shared definitions for the blind-mechanism emulator and the FSM side that drives it.
`default_nettype none
package persiana_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int POS_MAX_DEF  = 12;
  localparam int POS_MID_DEF  = 6;
  localparam int STEP_DIV_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/persiana_divisor.sv
// Prescaler: emits one step pulse every STEP_DIV step_en strobes while not cleared.
`default_nettype none
module persiana_divisor #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic step_en,
  input  logic clear,
  output logic step
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign step = step_en & ~clear & (div_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (step_en) begin
      div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/persiana_planta.sv
// Motorised blind emulator: turns subir/bajar motor commands into position and limit sensors.
`default_nettype none
module persiana_planta
  import persiana_pkg::*;
#(
  parameter int POS_W    = 4,
  parameter int POS_MAX  = POS_MAX_DEF,
  parameter int POS_MID  = POS_MID_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF,
  parameter int INIT_POS = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_en,
  input  logic             subir,
  input  logic             bajar,
  output logic             Ssup,
  output logic             Smed,
  output logic             Sinf,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       moving,
  output logic             stall,
  output logic             fault
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_CEN = POS_W'(POS_MID);
  localparam logic [POS_W-1:0] POS_INI = POS_W'(INIT_POS);

  state_t state;
  logic   travel;
  logic   step;

  assign travel = (state == UP) || (state == DOWN);
  assign stall  = ((state == UP) && (pos == POS_TOP)) || ((state == DOWN) && (pos == '0));
  assign moving = {(state == UP) & ~stall, (state == DOWN) & ~stall};
  assign fault  = (state == FAULT);
  assign Ssup   = (pos == POS_TOP);
  assign Smed   = (pos == POS_CEN);
  assign Sinf   = (pos == '0);

  // Counter is only live while travelling freely; entry into UP/DOWN is always from IDLE, so it starts at 0.
  persiana_divisor #(
    .STEP_DIV (STEP_DIV)
  ) u_divisor (
    .clk     (clk),
    .reset_n (reset_n),
    .step_en (step_en),
    .clear   (~travel | stall),
    .step    (step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pos   <= POS_INI;
    end else begin
      case (state)
        IDLE: begin
          if (subir && bajar)  state <= FAULT;
          else if (subir)      state <= UP;
          else if (bajar)      state <= DOWN;
        end
        UP: begin
          if (subir && bajar)  state <= FAULT;
          else if (!subir)     state <= IDLE;
        end
        DOWN: begin
          if (subir && bajar)  state <= FAULT;
          else if (!bajar)     state <= IDLE;
        end
        default: begin
          if (!subir && !bajar) state <= IDLE;
        end
      endcase

      if (step) begin
        pos <= (state == UP) ? pos + POS_W'(1) : pos - POS_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_persiana_planta.sv
// Randomised and directed bench for persiana_planta against an abstract travel model.
`default_nettype none
module tb_persiana_planta;

  localparam int POS_W    = 4;
  localparam int POS_MAX  = 12;
  localparam int POS_MID  = 6;
  localparam int STEP_DIV = 4;
  localparam int INIT_POS = 0;

  logic clk = 1'b0;
  logic reset_n, step_en, subir, bajar;
  logic Ssup, Smed, Sinf, stall, fault;
  logic [POS_W-1:0] pos;
  logic [1:0] moving;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  persiana_planta #(
    .POS_W(POS_W), .POS_MAX(POS_MAX), .POS_MID(POS_MID),
    .STEP_DIV(STEP_DIV), .INIT_POS(INIT_POS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .step_en(step_en), .subir(subir), .bajar(bajar),
    .Ssup(Ssup), .Smed(Smed), .Sinf(Sinf), .pos(pos), .moving(moving),
    .stall(stall), .fault(fault)
  );

  // Model: mode 0 idle, 1 up, 2 down, 3 fault; strobes counts step_en seen since travel began.
  typedef struct packed {
    int mode;
    int p;
    int strobes;
  } mdl_t;

  mdl_t m;

  function automatic bit blocked(mdl_t s);
    return (s.mode == 1 && s.p >= POS_MAX) || (s.mode == 2 && s.p <= 0);
  endfunction

  function automatic mdl_t model_next(mdl_t s, logic se, logic su, logic ba);
    mdl_t n = s;
    if ((s.mode == 1 || s.mode == 2) && !blocked(s)) begin
      if (se) begin
        n.strobes = s.strobes + 1;
        if (n.strobes % STEP_DIV == 0) n.p = s.p + ((s.mode == 1) ? 1 : -1);
      end
    end else begin
      n.strobes = 0;
    end
    case (s.mode)
      0: n.mode = (su && ba) ? 3 : su ? 1 : ba ? 2 : 0;
      1: n.mode = (su && ba) ? 3 : !su ? 0 : 1;
      2: n.mode = (su && ba) ? 3 : !ba ? 0 : 2;
      default: n.mode = (su || ba) ? 3 : 0;
    endcase
    if (n.mode != s.mode) n.strobes = 0;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{mode: 0, p: INIT_POS, strobes: 0};
    else          m <= model_next(m, step_en, subir, bajar);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expected_vec(mdl_t s);
    logic st = blocked(s);
    logic [1:0] mv = {s.mode == 1 && !st, s.mode == 2 && !st};
    return {18'd0, POS_W'(s.p), mv, st, s.mode == 3, s.p == POS_MAX, s.p == POS_MID, s.p == 0};
  endfunction

  always @(negedge clk) begin
    chk("cycle_outputs",
        {18'd0, pos, moving, stall, fault, Ssup, Smed, Sinf},
        expected_vec(m));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
  endtask

  int mode_r;

  initial begin
    reset_n = 1'b0; step_en = 1'b0; subir = 1'b0; bajar = 1'b0;
    cycles(3);
    chk("reset_pos", pos, 0);
    chk("reset_sensors", {Ssup, Smed, Sinf}, 3'b001);
    chk("reset_flags", {moving, stall, fault}, 4'b0000);
    reset_n = 1'b1;
    cycles(1);
    chk("after_reset_pos", pos, 0);

    // Full travel up: one entry cycle then 48 strobes
    subir = 1'b1; step_en = 1'b1;
    cycles(25);
    chk("mid_sensor_at_6", {pos, Smed}, {4'd6, 1'b1});
    cycles(24);
    chk("top_pos", pos, 12);
    chk("top_ssup", Ssup, 1);
    cycles(20);
    chk("top_stall", {pos, moving, stall}, {4'd12, 2'b00, 1'b1});

    // Fault from UP at pos 5
    pulse_reset();
    cycles(21);
    chk("up_to_5", pos, 5);
    bajar = 1'b1;
    cycles(1);
    chk("fault_entry", {pos, fault}, {4'd5, 1'b1});
    bajar = 1'b0;
    cycles(3);
    chk("fault_held", {pos, fault}, {4'd5, 1'b1});
    subir = 1'b0;
    cycles(1);
    chk("fault_exit", {pos, fault, moving}, {4'd5, 1'b0, 2'b00});

    // Reversal at pos 8 with two strobes into the step
    subir = 1'b1;
    cycles(15);
    chk("up_to_8", pos, 8);
    step_en = 1'b0; subir = 1'b0; bajar = 1'b1;
    cycles(1);
    chk("reverse_idle", moving, 2'b00);
    cycles(1);
    chk("reverse_down", moving, 2'b01);
    step_en = 1'b1;
    cycles(2);
    chk("no_step_at_2nd", pos, 8);
    cycles(1);
    chk("no_step_at_3rd", pos, 8);
    cycles(1);
    chk("step_at_4th", pos, 7);

    // No strobes: UP but no motion
    bajar = 1'b0;
    pulse_reset();
    subir = 1'b1; step_en = 1'b0;
    cycles(100);
    chk("no_strobe_up", {pos, moving, stall}, {4'd0, 2'b10, 1'b0});

    // Asynchronous reset mid-DOWN at pos 5
    step_en = 1'b1;
    cycles(20);
    step_en = 1'b0; subir = 1'b0; bajar = 1'b1;
    cycles(2);
    chk("down_pos5", {pos, moving}, {4'd5, 2'b01});
    step_en = 1'b1;
    cycles(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", {pos, Sinf, moving, fault}, {4'd0, 1'b1, 2'b00, 1'b0});
    cycles(1);
    reset_n = 1'b1;
    bajar = 1'b0;

    // Random command runs with random strobes
    mode_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mode_r = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      end
      subir   = (mode_r == 1) || (mode_r == 3);
      bajar   = (mode_r == 2) || (mode_r == 3);
      step_en = ($urandom_range(0, 2) != 0);
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
      end else begin
        cycles(1);
      end
    end

    subir = 1'b0; bajar = 1'b0; step_en = 1'b0;
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
